// File: rtl/tcb_pkg.sv
// Shared TCB helpers, independent of bus widths.
// Index-width helper keeps single-port instances at a 1-bit index.
package tcb_pkg;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcb_arb_rr.sv
// Rotating-priority encoder: first asserted request at or after i_ptr, wrapping.
// Purely combinational; the arbiter owns all state.
module tcb_arb_rr
    import tcb_pkg::*;
#(
    parameter  int MN = 2,
    localparam int IW = idx_width(MN)
) (
    input  logic [MN-1:0] i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_gnt,
    output logic          o_any
);

    logic [IW:0] w_idx;
    logic        w_hit;

    always_comb begin
        o_gnt = '0;
        w_hit = 1'b0;
        w_idx = '0;
        for (int k = 0; k < MN; k++) begin
            // ptr < MN and k < MN, so one subtraction is enough to wrap.
            w_idx = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(MN)) begin
                w_idx = w_idx - (IW+1)'(MN);
            end
            if (!w_hit && i_req[w_idx[IW-1:0]]) begin
                w_hit = 1'b1;
                o_gnt = w_idx[IW-1:0];
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/tcb_arb.sv
// Round-robin arbiter sharing one TCB subordinate among MN managers; grant is
// combinational, held while stalled, and responses are routed back after DLY cycles.
module tcb_arb
    import tcb_pkg::*;
#(
    parameter int MN  = 2,
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int BW  = DW/8,
    parameter int DLY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MN-1:0]          sub_vld,
    input  logic [MN-1:0]          sub_wen,
    input  logic [MN-1:0][BW-1:0]  sub_ben,
    input  logic [MN-1:0][AW-1:0]  sub_adr,
    input  logic [MN-1:0][DW-1:0]  sub_wdt,
    output logic [MN-1:0]          sub_rdy,
    output logic [MN-1:0][DW-1:0]  sub_rdt,
    output logic [MN-1:0]          sub_err,
    output logic                   man_vld,
    output logic                   man_wen,
    output logic [BW-1:0]          man_ben,
    output logic [AW-1:0]          man_adr,
    output logic [DW-1:0]          man_wdt,
    input  logic                   man_rdy,
    input  logic [DW-1:0]          man_rdt,
    input  logic                   man_err
);

    localparam int IW = idx_width(MN);

    if (MN < 2 || MN > 8) begin : g_chk_mn
        $error("tcb_arb: MN must be in 2..8");
    end
    if (DLY < 0 || DLY > 4) begin : g_chk_dly
        $error("tcb_arb: DLY must be in 0..4");
    end
    if (BW*8 != DW) begin : g_chk_bw
        $error("tcb_arb: BW*8 must equal DW");
    end

    logic [IW-1:0] r_ptr;
    logic          r_lck;
    logic [IW-1:0] r_lck_idx;

    logic [IW-1:0] w_rr_gnt;
    logic          w_rr_any;
    logic [IW-1:0] w_gnt;
    logic          w_vld;
    logic          w_trn;
    logic [IW-1:0] w_ptr_nxt;
    logic          w_rsp_vld;
    logic [IW-1:0] w_rsp_idx;

    tcb_arb_rr #(
        .MN (MN)
    ) u_rr (
        .i_req (sub_vld),
        .i_ptr (r_ptr),
        .o_gnt (w_rr_gnt),
        .o_any (w_rr_any)
    );

    // A stalled request keeps its grant; if its owner drops vld the bus idles one cycle.
    assign w_gnt     = r_lck ? r_lck_idx : w_rr_gnt;
    assign w_vld     = !rst && (r_lck ? sub_vld[r_lck_idx] : w_rr_any);
    assign w_trn     = w_vld && man_rdy;
    assign w_ptr_nxt = (w_gnt == IW'(MN-1)) ? '0 : w_gnt + IW'(1);

    always_comb begin
        man_vld = w_vld;
        man_wen = 1'b0;
        man_ben = '0;
        man_adr = '0;
        man_wdt = '0;
        sub_rdy = '0;
        if (w_vld) begin
            man_wen        = sub_wen[w_gnt];
            man_ben        = sub_ben[w_gnt];
            man_adr        = sub_adr[w_gnt];
            man_wdt        = sub_wdt[w_gnt];
            sub_rdy[w_gnt] = man_rdy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_lck     <= 1'b0;
            r_lck_idx <= '0;
        end else if (w_trn) begin
            r_ptr <= w_ptr_nxt;
            r_lck <= 1'b0;
        end else if (w_vld) begin
            r_lck     <= 1'b1;
            r_lck_idx <= w_gnt;
        end else if (r_lck) begin
            r_lck <= 1'b0;
        end
    end

    if (DLY == 0) begin : g_rsp_comb
        assign w_rsp_vld = w_trn;
        assign w_rsp_idx = w_gnt;
    end else begin : g_rsp_pipe
        logic [DLY-1:0]         r_pv;
        logic [DLY-1:0][IW-1:0] r_pidx;

        // Each stage carries its own owner index, so the pointer may move freely.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_pv   <= '0;
                r_pidx <= '0;
            end else begin
                r_pv[0]   <= w_trn;
                r_pidx[0] <= w_gnt;
                for (int k = 1; k < DLY; k++) begin
                    r_pv[k]   <= r_pv[k-1];
                    r_pidx[k] <= r_pidx[k-1];
                end
            end
        end

        assign w_rsp_vld = r_pv[DLY-1];
        assign w_rsp_idx = r_pidx[DLY-1];
    end

    always_comb begin
        sub_rdt = '0;
        sub_err = '0;
        if (!rst && w_rsp_vld) begin
            sub_rdt[w_rsp_idx] = man_rdt;
            sub_err[w_rsp_idx] = man_err;
        end
    end

endmodule

// File: tb/tb_tcb_arb.sv
// Bench for tcb_arb: MN=3/DLY=2 instance checked cycle by cycle against a
// reference arbiter and response scoreboard, plus a small MN=2/DLY=0 instance.
module tb_tcb_arb;

    localparam int MN  = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int DLY = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [MN-1:0]         sub_vld, sub_wen, sub_rdy, sub_err;
    logic [MN-1:0][BW-1:0] sub_ben;
    logic [MN-1:0][AW-1:0] sub_adr;
    logic [MN-1:0][DW-1:0] sub_wdt, sub_rdt;
    logic                  man_vld, man_wen, man_rdy, man_err;
    logic [BW-1:0]         man_ben;
    logic [AW-1:0]         man_adr;
    logic [DW-1:0]         man_wdt, man_rdt;

    tcb_arb #(.MN(MN), .AW(AW), .DW(DW), .BW(BW), .DLY(DLY)) u_dut (
        .clk(clk), .rst(rst),
        .sub_vld(sub_vld), .sub_wen(sub_wen), .sub_ben(sub_ben),
        .sub_adr(sub_adr), .sub_wdt(sub_wdt),
        .sub_rdy(sub_rdy), .sub_rdt(sub_rdt), .sub_err(sub_err),
        .man_vld(man_vld), .man_wen(man_wen), .man_ben(man_ben),
        .man_adr(man_adr), .man_wdt(man_wdt),
        .man_rdy(man_rdy), .man_rdt(man_rdt), .man_err(man_err)
    );

    logic                 z_rst;
    logic [1:0]           z_vld, z_wen, z_rdy_o, z_err_o;
    logic [1:0][BW-1:0]   z_ben;
    logic [1:0][AW-1:0]   z_adr;
    logic [1:0][DW-1:0]   z_wdt, z_rdt_o;
    logic                 z_man_vld, z_man_wen, z_man_rdy, z_man_err;
    logic [BW-1:0]        z_man_ben;
    logic [AW-1:0]        z_man_adr;
    logic [DW-1:0]        z_man_wdt, z_man_rdt;

    tcb_arb #(.MN(2), .AW(AW), .DW(DW), .BW(BW), .DLY(0)) u_dut_z (
        .clk(clk), .rst(z_rst),
        .sub_vld(z_vld), .sub_wen(z_wen), .sub_ben(z_ben),
        .sub_adr(z_adr), .sub_wdt(z_wdt),
        .sub_rdy(z_rdy_o), .sub_rdt(z_rdt_o), .sub_err(z_err_o),
        .man_vld(z_man_vld), .man_wen(z_man_wen), .man_ben(z_man_ben),
        .man_adr(z_man_adr), .man_wdt(z_man_wdt),
        .man_rdy(z_man_rdy), .man_rdt(z_man_rdt), .man_err(z_man_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        int port;
        int due;
    } rsp_t;

    rsp_t          sbq[$];
    int            m_ptr = 0;
    bit            m_lck = 1'b0;
    int            m_lidx = 0;
    int            seq[MN];
    int            cyc = 0;
    logic [MN-1:0] m_done = '0;

    logic          d_rst;
    logic [MN-1:0] d_vld;
    logic          d_rdy;

    task automatic tick();
        int                  g;
        bit                  ev;
        bit                  trn;
        logic [MN-1:0]       e_rdy;
        logic [MN-1:0]       e_err;
        logic [MN*DW-1:0]    e_rdt;
        logic [68:0]         e_req;
        rsp_t                r;
        @(negedge clk);
        rst     = d_rst;
        sub_vld = d_vld;
        man_rdy = d_rdy;
        for (int p = 0; p < MN; p++) begin
            sub_adr[p] = 32'((p + 1) * 4096 + seq[p]);
            sub_wen[p] = (seq[p] % 2) == 1;
            sub_ben[p] = BW'(seq[p] + p + 1);
            sub_wdt[p] = ~sub_adr[p];
        end
        man_rdt = 32'hA000_0000 + 32'(cyc);
        man_err = (cyc % 3) == 0;
        #1;
        g = 0; ev = 1'b0; trn = 1'b0;
        e_rdy = '0; e_err = '0; e_rdt = '0;
        m_done = '0;
        if (d_rst) begin
            m_ptr = 0;
            m_lck = 1'b0;
            sbq.delete();
        end else begin
            if (m_lck) begin
                g  = m_lidx;
                ev = d_vld[g];
            end else begin
                for (int k = 0; k < MN; k++) begin
                    int i;
                    i = (m_ptr + k) % MN;
                    if (!ev && d_vld[i]) begin
                        ev = 1'b1;
                        g  = i;
                    end
                end
            end
            trn = ev && d_rdy;
            if (trn) begin
                e_rdy[g] = 1'b1;
                sbq.push_back('{g, cyc + DLY});
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                r = sbq.pop_front();
                e_rdt[r.port*DW +: DW] = man_rdt;
                e_err[r.port]          = man_err;
            end
        end
        e_req = ev ? {sub_wen[g], sub_ben[g], sub_adr[g], sub_wdt[g]} : 69'd0;
        chk("man_vld", man_vld, ev);
        chk("man_req", {man_wen, man_ben, man_adr, man_wdt}, e_req);
        chk("sub_rdy", sub_rdy, e_rdy);
        chk("sub_rdt", sub_rdt, e_rdt);
        chk("sub_err", sub_err, e_err);
        if (!d_rst) begin
            if (trn) begin
                m_ptr     = (g + 1) % MN;
                m_lck     = 1'b0;
                m_done[g] = 1'b1;
                seq[g]++;
            end else if (ev) begin
                m_lck  = 1'b1;
                m_lidx = g;
            end else begin
                m_lck = 1'b0;
            end
        end
        cyc++;
    endtask

    initial begin
        for (int p = 0; p < MN; p++) seq[p] = 0;
        z_rst = 1'b1; z_vld = '0; z_wen = '0; z_ben = '0; z_adr = '0; z_wdt = '0;
        z_man_rdy = 1'b0; z_man_rdt = '0; z_man_err = 1'b0;

        // Reset held with every port requesting: all outputs forced low.
        d_rst = 1'b1; d_vld = '1; d_rdy = 1'b1;
        repeat (3) tick();

        // All ports requesting, subordinate always ready: rotation 0,1,2,0,1,2.
        d_rst = 1'b0;
        repeat (6) tick();

        // Port 0 stalls three cycles; port 1 joins mid-stall and must wait.
        d_vld = 3'b001; d_rdy = 1'b0; tick();
        d_vld = 3'b011; tick(); tick();
        d_rdy = 1'b1; tick();
        d_vld = 3'b010; tick();

        // Locked port 1 drops vld while port 2 and 0 request: bus idles, then ptr order.
        d_vld = 3'b010; d_rdy = 1'b0; tick();
        d_vld = 3'b101; tick();
        d_rdy = 1'b1; tick(); tick();

        // Reset with responses in flight: none may be delivered afterwards.
        d_vld = 3'b011; tick(); tick();
        d_rst = 1'b1; tick();
        d_rst = 1'b0; d_vld = '0; repeat (4) tick();
        d_vld = '1; tick();

        // Random traffic; a requester holds vld until its transfer completes.
        repeat (400) begin
            for (int p = 0; p < MN; p++) begin
                if (!(d_vld[p] && !m_done[p])) d_vld[p] = ($urandom_range(0, 2) != 0);
            end
            d_rdy = ($urandom_range(0, 3) != 0);
            tick();
        end
        d_vld = '0; d_rdy = 1'b1;
        repeat (DLY + 1) tick();
        chk("sbq_drained", 128'(sbq.size()), 128'd0);

        // Zero-delay instance: reset, then same-cycle response routing.
        @(negedge clk);
        z_vld = 2'b11; z_man_rdy = 1'b1;
        #1;
        chk("z_rst_vld", z_man_vld, 1'b0);
        chk("z_rst_rdy", z_rdy_o, 2'b00);
        @(negedge clk);
        z_rst = 1'b0; z_vld = 2'b10; z_adr[1] = 32'h44;
        z_man_rdt = 32'hDEAD_BEEF; z_man_err = 1'b1;
        #1;
        chk("z_vld", z_man_vld, 1'b1);
        chk("z_adr", z_man_adr, 32'h44);
        chk("z_rdy", z_rdy_o, 2'b10);
        chk("z_rdt", z_rdt_o, {32'hDEAD_BEEF, 32'h0});
        chk("z_err", z_err_o, 2'b10);
        @(negedge clk);
        z_vld = 2'b11; z_man_rdt = 32'h1234_5678; z_man_err = 1'b0;
        #1;
        chk("z_rdy_p0", z_rdy_o, 2'b01);
        chk("z_rdt_p0", z_rdt_o, {32'h0, 32'h1234_5678});
        @(negedge clk);
        #1;
        chk("z_rdy_p1", z_rdy_o, 2'b10);
        chk("z_rdt_p1", z_rdt_o, {32'h1234_5678, 32'h0});
        @(negedge clk);
        z_man_rdy = 1'b0;
        #1;
        chk("z_stall_vld", z_man_vld, 1'b1);
        chk("z_stall_rdt", z_rdt_o, 64'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
